// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl - scan scheduler for an 8-digit multiplexed 7-segment display.
//
// One shared 4-bit digit bus is time-sliced across 8 active-low digit enables.
// Each slot of DIV cycles starts with GUARD blank cycles (anti-ghosting). Then
// the digit is lit for a brightness-dependent ON window and dark for the rest
// of the slot. The 32-bit display word is captured once per frame, so a frame
// never mixes old and new digits.
//
// Build option: define SEG_LZB_EN to enable leading-zero blanking. Leading
// zero digits 7..1 of the frame snapshot stay dark through their ON window.
// Digit 0 is always lit.
//
// Ports
//   clk          in   system clock, posedge
//   rst          in   synchronous active-high reset
//   en           in   1 = scanning, 0 = dark / idle
//   data[31:0]   in   packed digits, data[4k+3:4k] = digit k (k=0 rightmost)
//   brightness   in   duty level 0..15, sampled at each slot start
//   sel[2:0]     out  digit index of the current slot
//   an[7:0]      out  digit enables, active-low, at most one bit low
//   digit[3:0]   out  snapshot nibble for digit sel
//   frame_start  out  one-cycle pulse as slot 0 of a new frame begins
//
// State table
//   state    | meaning
//   ST_IDLE  | not scanning, all digits dark
//   ST_GUARD | cnt < GUARD, blank lead-in of a slot
//   ST_ON    | GUARD <= cnt < on_end, digit sel driven
//   ST_OFF   | on_end <= cnt < DIV, dark remainder of the slot
module seg_scan_ctrl #(
  parameter int DIV   = 1000,
  parameter int GUARD = 16,
  parameter int CW    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] data,
  input  logic [3:0]  brightness,
  output logic [2:0]  sel,
  output logic [7:0]  an,
  output logic [3:0]  digit,
  output logic        frame_start
);

  localparam int OW = CW + 5;
  localparam logic [OW-1:0] SPAN     = OW'(DIV - GUARD);
  localparam logic [OW-1:0] GUARD_W  = OW'(GUARD);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_GUARD, ST_ON, ST_OFF} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    sel_d;
  logic [7:0]    an_d;
  logic [3:0]    digit_d;
  logic          fs_d;
  logic [31:0]   snap, snap_d;
  logic [3:0]    bri_q, bri_d;
  logic [OW-1:0] on_prod, on_end;
  logic [OW-1:0] cnt_w;
  logic          digit_lit;

`ifdef SEG_LZB_EN
  logic [7:0] lzb_mask, lzb_mask_d;

  // Bit k set when digits 7..k of the word are all zero; bit 0 never set.
  function automatic logic [7:0] lzb_calc(input logic [31:0] w);
    logic z;
    lzb_calc = 8'h00;
    z = 1'b1;
    for (int k = 7; k >= 1; k--) begin
      z = z & (w[4*k +: 4] == 4'd0);
      lzb_calc[k] = z;
    end
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      sel         <= 3'd0;
      an          <= 8'hFF;
      digit       <= 4'd0;
      frame_start <= 1'b0;
      snap        <= 32'd0;
      bri_q       <= 4'd0;
`ifdef SEG_LZB_EN
      lzb_mask    <= 8'h00;
`endif
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      sel         <= sel_d;
      an          <= an_d;
      digit       <= digit_d;
      frame_start <= fs_d;
      snap        <= snap_d;
      bri_q       <= bri_d;
`ifdef SEG_LZB_EN
      lzb_mask    <= lzb_mask_d;
`endif
    end
  end

  always_comb begin
    cnt_d     = cnt;
    sel_d     = sel;
    snap_d    = snap;
    fs_d      = 1'b0;
    bri_d     = bri_q;
    state_d   = state;
    digit_lit = 1'b1;

    // Brightness is taken once per slot so the ON window is stable within it.
    if (cnt == '0)
      bri_d = brightness;

    if (!en) begin
      cnt_d = '0;
      sel_d = 3'd0;
    end else if (state == ST_IDLE) begin
      cnt_d  = '0;
      sel_d  = 3'd0;
      snap_d = data;
      fs_d   = 1'b1;
    end else if (cnt == CNT_LAST) begin
      cnt_d = '0;
      sel_d = sel + 3'd1;
      if (sel == 3'd7) begin
        snap_d = data;
        fs_d   = 1'b1;
      end
    end else begin
      cnt_d = cnt + 1'b1;
    end

    // Widened so bri=15 lands exactly on DIV with no truncation.
    on_prod = (OW'(bri_d) + OW'(1)) * SPAN;
    on_end  = GUARD_W + (on_prod >> 4);
    cnt_w   = OW'(cnt_d);

    // Phase is derived from the post-edge count so outputs line up with it.
    if (!en)
      state_d = ST_IDLE;
    else if (cnt_w < GUARD_W)
      state_d = ST_GUARD;
    else if (cnt_w < on_end)
      state_d = ST_ON;
    else
      state_d = ST_OFF;

`ifdef SEG_LZB_EN
    lzb_mask_d = lzb_mask;
    if (fs_d)
      lzb_mask_d = lzb_calc(snap_d);
    digit_lit = !lzb_mask_d[sel_d];
`endif

    an_d    = (state_d == ST_ON && digit_lit) ? ~(8'b1 << sel_d) : 8'hFF;
    digit_d = snap_d[{sel_d, 2'b00} +: 4];
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

  localparam int DIV = 40;
  localparam int G   = 8;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [31:0] data;
  logic [3:0]  brightness;
  logic [2:0]  sel;
  logic [7:0]  an;
  logic [3:0]  digit;
  logic        frame_start;

  seg_scan_ctrl #(.DIV(DIV), .GUARD(G), .CW(16)) dut (
    .clk(clk), .rst(rst), .en(en), .data(data), .brightness(brightness),
    .sel(sel), .an(an), .digit(digit), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] an;
    logic [2:0] sel;
    logic [3:0] digit;
    logic       fs;
  } samp_t;

  samp_t exp_q[$];
  samp_t mon_e;
  int    total = 0;
  int    bad   = 0;
  string phase = "reset";

  // Monitor: one expected sample per cycle while the scoreboard holds any.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      total++;
      if ({an, sel, digit, frame_start} !== mon_e) begin
        bad++;
        $display("FAIL %s: got an=%h sel=%0d digit=%h fs=%b, want an=%h sel=%0d digit=%h fs=%b",
                 phase, an, sel, digit, frame_start, mon_e.an, mon_e.sel, mon_e.digit, mon_e.fs);
      end
    end
  end

  function automatic logic [3:0] nib(input logic [31:0] w, input int k);
    return w[4*k +: 4];
  endfunction

  task automatic push(input logic [7:0] a, input logic [2:0] s, input logic [3:0] d, input logic f);
    samp_t x;
    x.an = a; x.sel = s; x.digit = d; x.fs = f;
    exp_q.push_back(x);
  endtask

  task automatic push_guard(input logic [2:0] s, input logic [3:0] d, input logic fs0);
    for (int i = 0; i < G; i++) push(8'hFF, s, d, (i == 0) ? fs0 : 1'b0);
  endtask

  task automatic push_on(input logic [2:0] s, input logic [3:0] d, input int n, input logic lit);
    logic [7:0] a;
    a = lit ? ~(8'b1 << s) : 8'hFF;
    for (int i = 0; i < n; i++) push(a, s, d, 1'b0);
  endtask

  task automatic push_off(input logic [2:0] s, input logic [3:0] d, input int n);
    for (int i = 0; i < n; i++) push(8'hFF, s, d, 1'b0);
  endtask

  task automatic push_slot(input logic [2:0] s, input logic [3:0] d, input int on, input int off,
                           input logic fs0, input logic lit);
    push_guard(s, d, fs0);
    push_on(s, d, on, lit);
    push_off(s, d, off);
  endtask

  task automatic push_frame(input logic [31:0] w, input int on, input int off, input logic [7:0] lit);
    for (int s = 0; s < 8; s++) push_slot(3'(s), nib(w, s), on, off, s == 0, lit[s]);
  endtask

  // Returns on the negedge after the last queued sample has been checked.
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s: timeout with %0d samples left, want 0", phase, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time exceeded, want finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] w;
  logic [7:0]  lit_a, lit_b;

  initial begin
    rst = 1'b1; en = 1'b0; data = 32'd0; brightness = 4'd0;
    push(8'hFF, 3'd0, 4'd0, 1'b0);
    push(8'hFF, 3'd0, 4'd0, 1'b0);
    drain();

    phase = "full_bright";
    rst = 1'b0; en = 1'b1; brightness = 4'd15; data = 32'h7654_3210;
    push_frame(32'h7654_3210, 32, 0, 8'hFF);
    drain();

    phase = "bri7";
    brightness = 4'd7;
    push_frame(32'h7654_3210, 16, 16, 8'hFF);
    drain();

    phase = "bri0";
    brightness = 4'd0;
    push_slot(3'd0, 4'd0, 2, 30, 1'b1, 1'b1);
    drain();
    brightness = 4'd15;
    push_slot(3'd1, 4'd1, 32, 0, 1'b0, 1'b1);
    drain();

    phase = "bri_midslot";
    push_guard(3'd2, 4'd2, 1'b0);
    push_on(3'd2, 4'd2, 13, 1'b1);
    drain();
    brightness = 4'd0;
    push_on(3'd2, 4'd2, 19, 1'b1);
    drain();
    push_slot(3'd3, 4'd3, 2, 30, 1'b0, 1'b1);
    drain();
    brightness = 4'd15;
    for (int s = 4; s < 8; s++) push_slot(3'(s), 4'(s), 32, 0, 1'b0, 1'b1);
    drain();

    phase = "snapshot";
    data = 32'h1111_1111;
    for (int s = 0; s < 3; s++) push_slot(3'(s), 4'd1, 32, 0, s == 0, 1'b1);
    push_guard(3'd3, 4'd1, 1'b0);
    push_on(3'd3, 4'd1, 12, 1'b1);
    drain();
    data = 32'h2222_2222;
    push_on(3'd3, 4'd1, 20, 1'b1);
    for (int s = 4; s < 8; s++) push_slot(3'(s), 4'd1, 32, 0, 1'b0, 1'b1);
    push_frame(32'h2222_2222, 32, 0, 8'hFF);
    drain();

    phase = "en_drop";
    w = 32'h89AB_CDEF;
    data = w;
    for (int s = 0; s < 5; s++) push_slot(3'(s), nib(w, s), 32, 0, s == 0, 1'b1);
    push_guard(3'd5, nib(w, 5), 1'b0);
    push_on(3'd5, nib(w, 5), 13, 1'b1);
    drain();
    en = 1'b0;
    for (int i = 0; i < 3; i++) push(8'hFF, 3'd0, 4'hF, 1'b0);
    drain();
    phase = "en_resume";
    w = 32'h1246_8ACE;
    data = w; en = 1'b1;
    for (int s = 0; s < 6; s++) push_slot(3'(s), nib(w, s), 32, 0, s == 0, 1'b1);
    push_guard(3'd6, nib(w, 6), 1'b0);
    push_on(3'd6, nib(w, 6), 5, 1'b1);
    drain();

    phase = "rst_mid";
    rst = 1'b1;
    push(8'hFF, 3'd0, 4'd0, 1'b0);
    push(8'hFF, 3'd0, 4'd0, 1'b0);
    drain();
    phase = "rst_restart";
    rst = 1'b0;
    push_frame(w, 32, 0, 8'hFF);
    drain();

`ifdef SEG_LZB_EN
    lit_a = 8'b0000_0111;
    lit_b = 8'b0000_0001;
`else
    lit_a = 8'hFF;
    lit_b = 8'hFF;
`endif
    phase = "lzb_0120";
    en = 1'b0;
    push(8'hFF, 3'd0, 4'hE, 1'b0);
    push(8'hFF, 3'd0, 4'hE, 1'b0);
    drain();
    data = 32'h0000_0120; en = 1'b1;
    push_frame(32'h0000_0120, 32, 0, lit_a);
    drain();

    phase = "lzb_zero";
    en = 1'b0;
    push(8'hFF, 3'd0, 4'd0, 1'b0);
    push(8'hFF, 3'd0, 4'd0, 1'b0);
    drain();
    data = 32'd0; en = 1'b1;
    push_frame(32'd0, 32, 0, lit_b);
    drain();

    phase = "final_idle";
    en = 1'b0;
    push(8'hFF, 3'd0, 4'd0, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
